dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/rv_mem_pkg.sv | 61 ++++++
 rtl/dmem_responder_load_extend.sv | 28 ++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared data-memory definitions: funct3 size codes, responder states
// and the small decode helpers used by the store and error paths.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic f3_legal(
    input logic       write,
    input logic [2:0] f3
  );
    if (write)
      return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // f3[1:0] carries the access size for every legal code
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    return (f3[1:0] == 2'b01 && a[0]) ||
           (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [3:0] store_be(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] be;
    unique case (1'b1)
      f3 == F3_B: be = 4'b0001 << a;
      f3 == F3_H: be = a[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] l;
    unique case (1'b1)
      f3 == F3_B: l = {4{d[7:0]}};
      f3 == F3_H: l = {2{d[15:0]}};
      default:    l = d;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/dmem_responder_load_extend.sv
// Load lane/half selection with sign or zero extension.
// Purely combinational; illegal codes pass the word through.
module load_extend
  import rv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{addr, 3'b000} +: 8];
    h    = addr[1] ? word[31:16] : word[15:0];
    data = word;
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_BU:   data = {24'd0, b};
      F3_HU:   data = {16'd0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data memory slave: one request in flight,
// store commit and load read on the edge entering RESP.
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW =
    DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

  state_t state;
  state_t state_nx;

  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_f3;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        commit;
  logic        eff_write;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [2:0]  eff_f3;
  logic        range_err;
  logic        err;
  logic [AW-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] load_data;
  logic [3:0]  be;
  logic [31:0] lanes;

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  // With zero latency the edge that accepts also enters RESP,
  // so the live request must be used instead of the capture.
  assign eff_write = (state == IDLE) ? req_write  : cap_write;
  assign eff_addr  = (state == IDLE) ? req_addr   : cap_addr;
  assign eff_wdata = (state == IDLE) ? req_wdata  : cap_wdata;
  assign eff_f3    = (state == IDLE) ? req_funct3 : cap_f3;

  assign range_err =
    {2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign err = range_err ||
               !f3_legal(eff_write, eff_f3) ||
               misaligned(eff_f3, eff_addr[1:0]);

  assign idx     = eff_addr[AW+1:2];
  assign rd_word = mem[idx];
  assign be      = store_be(eff_f3, eff_addr[1:0]);
  assign lanes   = store_lanes(eff_f3, eff_wdata);
  assign commit  = enter_resp && eff_write && !err;

  load_extend u_load_extend (
    .word   (rd_word),
    .addr   (eff_addr[1:0]),
    .funct3 (eff_f3),
    .data   (load_data)
  );

  always_comb begin
    state_nx   = state;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_f3    <= 3'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_f3    <= req_funct3;
        cnt       <= (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (err || eff_write) ? 32'd0 : load_data;
      end
    end
  end

  // Storage keeps its contents across reset
  always_ff @(posedge clk) begin
    if (rst_n && commit) begin
      for (int i = 0; i < 4; i++)
        if (be[i])
          mem[idx][8*i +: 8] <= lanes[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-addressed reference model,
// per-cycle compare process, directed and random traffic.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;

  logic        a_req_valid, a_req_ready;
  logic        a_rsp_valid, a_rsp_ready;
  logic [31:0] a_rsp_rdata;
  logic        a_rsp_err;

  logic        b_req_valid, b_req_ready;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_rdata;
  logic        b_rsp_err;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (a_rsp_valid),
    .rsp_ready  (a_rsp_ready),
    .rsp_rdata  (a_rsp_rdata),
    .rsp_err    (a_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (b_rsp_valid),
    .rsp_ready  (b_rsp_ready),
    .rsp_rdata  (b_rsp_rdata),
    .rsp_err    (b_rsp_err)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model of the LATENCY=2 instance, byte addressed
  bit [7:0]    mm [4*DEPTH];
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_rdata = 0;
  logic        m_err   = 0;
  bit          m_st    = 0;
  logic [31:0] m_addr, m_wdata;
  int          m_size  = 1;

  task automatic model_capture();
    bit legal;
    logic [31:0] v;
    m_size  = (req_funct3[1:0] == 2'b00) ? 1 :
              (req_funct3[1:0] == 2'b01) ? 2 : 4;
    legal   = req_write ? (req_funct3 <= 3'd2) :
              (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    m_err   = !legal || (req_addr % m_size != 0) ||
              ((req_addr / 4) >= DEPTH);
    m_addr  = req_addr;
    m_wdata = req_wdata;
    m_st    = req_write && !m_err;
    m_rdata = 0;
    if (!m_err && !req_write) begin
      v = 0;
      for (int i = 0; i < m_size; i++)
        v = v | (32'(mm[req_addr + i]) << (8 * i));
      if (!req_funct3[2] && m_size == 1 && v[7])
        v = v | 32'hFFFFFF00;
      if (!req_funct3[2] && m_size == 2 && v[15])
        v = v | 32'hFFFF0000;
      m_rdata = v;
    end
  endtask

  task automatic model_commit();
    if (m_st)
      for (int i = 0; i < m_size; i++)
        mm[m_addr + i] = m_wdata[8*i +: 8];
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (a_req_valid) begin
        model_capture();
        m_left  = LAT;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        model_commit();
        m_phase = 2;
      end
    end else if (a_rsp_ready) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", a_req_ready, (m_phase == 0) && rst_n);
      chk("rsp_valid", a_rsp_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("rsp_rdata", a_rsp_rdata, m_rdata);
        chk("rsp_err", a_rsp_err, m_err);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic txn(input bit sel, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input int hold,
                     output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    tick();
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f3;
    if (sel) b_req_valid = 1'b1;
    else     a_req_valid = 1'b1;
    n = 0;
    while (!(sel ? b_req_ready : a_req_ready) && n < 50) begin
      tick();
      n++;
    end
    chk("accept", sel ? b_req_ready : a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    lat = 1;
    while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 40) begin
      tick();
      lat++;
    end
    chk("rsp_seen", sel ? b_rsp_valid : a_rsp_valid, 1);
    rd = sel ? b_rsp_rdata : a_rsp_rdata;
    er = sel ? b_rsp_err : a_rsp_err;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", sel ? b_rsp_valid : a_rsp_valid, 1);
      chk("hold_rdata", sel ? b_rsp_rdata : a_rsp_rdata, rd);
      chk("hold_err", sel ? b_rsp_err : a_rsp_err, er);
      chk("hold_req_ready", sel ? b_req_ready : a_req_ready, 0);
    end
    if (sel) b_rsp_ready = 1'b1;
    else     a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst_n = 0;
    a_req_valid = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_rsp_ready = 0;
    req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
    repeat (2) tick();
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_rdata", a_rsp_rdata, 0);
    chk("rst_rsp_err", a_rsp_err, 0);
    chk("rst_req_ready", a_req_ready, 0);
    chk("rst0_rsp_valid", b_rsp_valid, 0);
    rst_n  = 1;
    chk_on = 1;
    tick();
    chk("post_rst_ready", a_req_ready, 1);

    for (int i = 0; i < DEPTH; i++)
      txn(0, 1, 32'(4 * i), $urandom(), 3'b010, 0, rd, er, lat);

    txn(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd, er, lat);
    chk("sw_latency", 32'(lat), 3);
    chk("sw_err", er, 0);
    txn(0, 0, 32'h10, 0, 3'b010, 0, rd, er, lat);
    chk("lw_rdata", rd, 32'hDEADBEEF);

    txn(0, 1, 32'h11, 32'h80, 3'b000, 0, rd, er, lat);
    txn(0, 0, 32'h11, 0, 3'b000, 0, rd, er, lat);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    txn(0, 0, 32'h11, 0, 3'b100, 0, rd, er, lat);
    chk("lbu_rdata", rd, 32'h00000080);
    txn(0, 0, 32'h10, 0, 3'b010, 0, rd, er, lat);
    chk("lw_after_sb", rd, 32'hDEAD80EF);

    txn(0, 0, 32'h13, 0, 3'b001, 0, rd, er, lat);
    chk("lh_mis_err", er, 1);
    chk("lh_mis_rdata", rd, 0);
    txn(0, 1, 32'h12, 32'h12345678, 3'b010, 0, rd, er, lat);
    chk("sw_mis_err", er, 1);
    txn(0, 0, 32'h10, 0, 3'b010, 0, rd, er, lat);
    chk("lw_after_bad_sw", rd, 32'hDEAD80EF);

    txn(0, 0, 32'(4 * DEPTH), 0, 3'b010, 0, rd, er, lat);
    chk("lw_range_err", er, 1);
    txn(0, 0, 32'h10, 0, 3'b011, 0, rd, er, lat);
    chk("f3_011_err", er, 1);

    txn(0, 0, 32'h10, 0, 3'b010, 5, rd, er, lat);
    chk("hold_lw_rdata", rd, 32'hDEAD80EF);

    txn(0, 1, 32'h20, 32'h00000055, 3'b010, 0, rd, er, lat);
    tick();
    req_write = 1; req_addr = 32'h20;
    req_wdata = 32'h1; req_funct3 = 3'b010;
    a_req_valid = 1;
    chk("abort_accept", a_req_ready, 1);
    tick();
    a_req_valid = 0;
    rst_n = 0;
    tick();
    chk("abort_no_rsp", a_rsp_valid, 0);
    rst_n = 1;
    #1;
    chk("abort_idle", a_req_ready, 1);
    tick();
    chk("abort_no_rsp2", a_rsp_valid, 0);
    txn(0, 0, 32'h20, 0, 3'b010, 0, rd, er, lat);
    chk("abort_kept", rd, 32'h00000055);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 8)
        f3 = legal_f3[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)
        a = $urandom() | 32'h0000_0400;
      else
        a = 32'($urandom_range(0, 4 * DEPTH - 1));
      txn(0, 1'($urandom_range(0, 1)), a, $urandom(), f3,
          $urandom_range(0, 2), rd, er, lat);
    end

    txn(1, 1, 32'h40, 32'hCAFEF00D, 3'b010, 0, rd, er, lat);
    chk("lat0_sw_latency", 32'(lat), 1);
    chk("lat0_sw_err", er, 0);
    txn(1, 0, 32'h42, 0, 3'b001, 0, rd, er, lat);
    chk("lat0_lh_latency", 32'(lat), 1);
    chk("lat0_lh_rdata", rd, 32'hFFFFCAFE);
    txn(1, 0, 32'h42, 0, 3'b101, 0, rd, er, lat);
    chk("lat0_lhu_rdata", rd, 32'h0000CAFE);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
